// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register: valid/ready on both sides, two-entry skid buffer,
// flush for branch/exception kill and a saturating back-pressure counter.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] regA_in,
    input  logic [DATA_W-1:0] regB_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] regC_adress_in,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] regA_out,
    output logic [DATA_W-1:0] regB_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [ADDR_W-1:0] regC_adress_out,

    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam int PAY_W = CTRL_W + 3 * DATA_W + ADDR_W;

    // Encoding is {main_valid, skid_valid} so the valid bits fall straight out of the state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [PAY_W-1:0]  main_q, main_d;
    logic [PAY_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;
    logic [PAY_W-1:0]  in_payload;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];
    assign in_payload = {ctrl_in, regA_in, regB_in, pc_in, regC_adress_in};

    // in_ready comes only from flops, so no combinational path from out_ready reaches decode.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_ONE;
                    main_d  = in_payload;
                end
            end
            S_ONE: begin
                if (in_fire && out_ready) begin
                    main_d = in_payload;
                end else if (in_fire) begin
                    state_d = S_TWO;
                    skid_d  = in_payload;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush kills everything; payload is left alone so data outputs keep their last value.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; payload flops are reset too,
    // because the data outputs must read zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic [CTRL_W-1:0] main_ctrl;

    assign {main_ctrl, regA_out, regB_out, pc_out, regC_adress_out} = main_q;
    assign ctrl_out  = main_valid ? main_ctrl : '0;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: queue scoreboard of accepted beats, occupancy
// model for in_ready/out_valid, and stall-counter models for 16-bit and 4-bit counters.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [3:0]  rc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush, stall_clr;
    logic [10:0] ctrl_in;
    logic [31:0] regA_in, regB_in, pc_in;
    logic [3:0]  regC_adress_in;

    logic        in_ready, out_valid;
    logic [10:0] ctrl_out;
    logic [31:0] regA_out, regB_out, pc_out;
    logic [3:0]  regC_adress_out;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [10:0] s_ctrl_out;
    logic [31:0] s_regA_out, s_regB_out, s_pc_out;
    logic [3:0]  s_regC_adress_out;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .ctrl_in(ctrl_in),
        .regA_in(regA_in), .regB_in(regB_in), .pc_in(pc_in), .regC_adress_in(regC_adress_in),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
        .regA_out(regA_out), .regB_out(regB_out), .pc_out(pc_out), .regC_adress_out(regC_adress_out),
        .flush(flush), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .ctrl_in(ctrl_in),
        .regA_in(regA_in), .regB_in(regB_in), .pc_in(pc_in), .regC_adress_in(regC_adress_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .ctrl_out(s_ctrl_out),
        .regA_out(s_regA_out), .regB_out(s_regB_out), .pc_out(s_pc_out), .regC_adress_out(s_regC_adress_out),
        .flush(flush), .stall_cnt(s_stall_cnt), .stall_clr(stall_clr)
    );

    int    n_checks = 0;
    int    n_passed = 0;
    beat_t sb_q[$];
    beat_t last_main;
    int    exp_cnt;
    int    exp_cnt4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy);
        in_valid       = v;
        pc_in          = pc;
        regA_in        = pc ^ 32'hA5A5_0000;
        regB_in        = ~pc;
        ctrl_in        = pc[10:0] | 11'h001;
        regC_adress_in = pc[5:2];
        out_ready      = ordy;
    endtask

    // Compare outputs against the scoreboard, advance the model, then step one clock.
    task automatic tick();
        int    occ;
        logic  exp_rdy, fire_in, fire_out;
        beat_t exp_b;
        occ     = sb_q.size();
        exp_rdy = (occ < 2);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, occ > 0);
        if (occ > 0) begin
            last_main = sb_q[0];
            check("ctrl_out", ctrl_out, sb_q[0].ctrl);
        end else begin
            check("ctrl_out_bubble", ctrl_out, 0);
        end
        exp_b = last_main;
        check("regA_out", regA_out, exp_b.a);
        check("regB_out", regB_out, exp_b.b);
        check("pc_out", pc_out, exp_b.pc);
        check("regC_adress_out", regC_adress_out, exp_b.rc);
        check("stall_cnt", stall_cnt, exp_cnt);
        check("stall_cnt_w4", s_stall_cnt, exp_cnt4);

        fire_in  = in_valid && exp_rdy;
        fire_out = (occ > 0) && out_ready;
        if (stall_clr) begin
            exp_cnt  = 0;
            exp_cnt4 = 0;
        end else if ((occ > 0) && !out_ready) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        if (fire_out) void'(sb_q.pop_front());
        if (fire_in) sb_q.push_back('{ctrl_in, regA_in, regB_in, pc_in, regC_adress_in});
        if (flush) sb_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        last_main = '0;
        exp_cnt   = 0;
        exp_cnt4  = 0;

        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctrl_out", ctrl_out, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_regA_out", regA_out, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        tick();

        // Back-pressure: three stalled cycles, then drain.
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        drive(1'b1, 32'h300, 1'b1); tick();
        drive(1'b1, 32'h304, 1'b0); tick();
        check("bp_in_ready_low", in_ready, 0);
        drive(1'b1, 32'h308, 1'b0); tick();
        drive(1'b1, 32'h308, 1'b0); tick();
        check("bp_stall_cnt", stall_cnt, 3);
        drive(1'b1, 32'h308, 1'b1); tick();
        drive(1'b1, 32'h308, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b1); tick();
        tick();

        // Flush in TWO with a beat offered in the same cycle.
        drive(1'b1, 32'h200, 1'b0); tick();
        drive(1'b1, 32'h204, 1'b0); tick();
        drive(1'b1, 32'h208, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check("flush_out_valid", out_valid, 0);
        check("flush_ctrl_out", ctrl_out, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_pc_out_held", pc_out, 32'h200);
        tick();

        // Bubble with ctrl_in all ones.
        drive(1'b0, 32'hFFFF_FFFF, 1'b1);
        ctrl_in = '1;
        tick();
        tick();
        check("bubble_regA_held", regA_out, 32'h200 ^ 32'hA5A5_0000);

        // Flush and stall_clr together.
        drive(1'b1, 32'h400, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0); tick();
        flush     = 1'b1;
        stall_clr = 1'b1;
        tick();
        flush     = 1'b0;
        stall_clr = 1'b0;
        check("flush_clr_cnt", stall_cnt, 0);
        check("flush_clr_valid", out_valid, 0);

        // Asynchronous reset between edges while in TWO.
        drive(1'b1, 32'h500, 1'b0); tick();
        drive(1'b1, 32'h504, 1'b0); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_ctrl_out", ctrl_out, 0);
        check("arst_pc_out", pc_out, 0);
        check("arst_regB_out", regB_out, 0);
        check("arst_regC_out", regC_adress_out, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        sb_q.delete();
        last_main = '0;
        exp_cnt   = 0;
        exp_cnt4  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1); tick();
        drive(1'b1, 32'h600, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b1); tick();

        // Saturation of the 4-bit counter.
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        drive(1'b1, 32'h700, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt_w4", s_stall_cnt, 15);
        check("sat_cnt_w16", stall_cnt, 20);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sat_clr_w4", s_stall_cnt, 0);
        drive(1'b0, 32'h0, 1'b1); tick();
        tick();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised ID/EX pipeline stage register with a valid/ready handshake on both sides, a two-entry skid buffer, flush for branch/exception kill, and a saturating back-pressure counter. It sits between the decode stage and the execute stage and replaces the plain free-running register. Decode can now be stalled without combinational ready paths, and execute sees NOP bubbles whenever no valid instruction is present.

## Interface
Parameters:
- DATA_W, 32, width of operand A, operand B and PC
- ADDR_W, 4, width of the destination register address
- CTRL_W, 11, width of the packed control bus: {write_inst, regs_bank[1:0], alu[5:0], data_mem, mux4}
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered
- ctrl_in  in  CTRL_W  control bus from decode
- regA_in, regB_in, pc_in  in  DATA_W  operands and PC
- regC_adress_in  in  ADDR_W  destination register address
- out_valid  out  1  execute holds a valid instruction
- out_ready  in  1  execute consumes the instruction
- ctrl_out  out  CTRL_W  control bus; forced to 0 when out_valid=0
- regA_out, regB_out, pc_out  out  DATA_W  operands and PC
- regC_adress_out  out  ADDR_W  destination address
- flush  in  1  synchronous kill of all held and incoming instructions
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit. Payload is {ctrl, regA, regB, pc, regC_adress}.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid. It depends only on flops and has no combinational path from out_ready.
- out_valid = main_valid. ctrl_out = main_valid ? main.ctrl : 0.
- Data outputs hold their last value when invalid.
- States (main_valid, skid_valid):
  - EMPTY(0,0):
    - in_fire -> ONE, main <= input.
  - ONE(1,0):
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & !out_ready -> TWO, skid <= input, main held.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - TWO(1,1): in_ready=0, so input is ignored.
    - out_fire -> ONE, main <= skid, skid_valid <= 0.
    - Otherwise hold.
- Ordering is strictly FIFO. The skid contents never bypass main.
- flush:
  - Next state is EMPTY regardless of handshakes. Both valid bits are cleared.
  - A beat accepted (in_fire) in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes. The current outputs are unchanged in that cycle.
  - Payload flops need not be cleared.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr sets it to 0 and has priority over increment.
  - flush does not affect it.

## Timing
- Reset (rst_n=0, async): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, ctrl_out=0, regA_out=regB_out=pc_out=0, regC_adress_out=0, stall_cnt=0. All flops clear immediately, without waiting for clk.
- Reset deassertion is synchronous to clk. The first accept can occur on the first rising edge with rst_n=1.
- Latency: an in_fire at edge N makes the data visible on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle when out_ready is held at 1.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Reset asserted mid-operation drops all held instructions. Nothing is replayed.
- Simultaneous flush and stall_clr: both take effect independently.

## Test plan
- Streaming: out_ready=1, 8 back-to-back beats with pc_in=0x100, 0x104, …, 0x11C. Required: pc_out follows one cycle later, and out_valid=1 for 8 consecutive cycles.
- Back-pressure: stream with out_ready=0 for 3 cycles, then 1.
  - in_ready=0 from the second stalled cycle onward.
  - No beat is lost or duplicated; the pc sequence is intact.
  - stall_cnt=3.
- Flush in TWO state (pc 0x200 in main, 0x204 in skid) with in_valid=1, pc_in=0x208. Required: the next cycle has out_valid=0, ctrl_out=0 and in_ready=1, and 0x208 never appears.
- Bubble: in_valid=0 with ctrl_in=all ones. Required: ctrl_out=0 whenever out_valid=0, and regA_out/regB_out hold their previous values.
- Async reset mid-stream: pull rst_n low between edges while in TWO. Required: all outputs go to zero immediately and in_ready=1.
- Saturation: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt=15; stall_clr then gives 0 the next cycle.
